// File: rtl/id_stage_pkg.sv
// Shared decode definitions for the ID stage: opcodes, function fields,
// ALU operation encodings and the registered control payload.
package id_stage_pkg;

  localparam int unsigned INST_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned ALU_OP_W   = 4;

  // Major opcodes
  localparam logic [6:0] INST_TYPE_I       = 7'b0010011;
  localparam logic [6:0] INST_TYPE_R       = 7'b0110011;
  localparam logic [6:0] INST_TYPE_U_LUI   = 7'b0110111;
  localparam logic [6:0] INST_TYPE_U_AUIPC = 7'b0010111;
  localparam logic [6:0] INST_TYPE_B       = 7'b1100011;
  localparam logic [6:0] INST_JAL          = 7'b1101111;

  // OP / OP-IMM func3
  localparam logic [2:0] INST_ADD  = 3'b000;
  localparam logic [2:0] INST_SLL  = 3'b001;
  localparam logic [2:0] INST_SLT  = 3'b010;
  localparam logic [2:0] INST_SLTU = 3'b011;
  localparam logic [2:0] INST_XOR  = 3'b100;
  localparam logic [2:0] INST_SR   = 3'b101;
  localparam logic [2:0] INST_OR   = 3'b110;
  localparam logic [2:0] INST_AND  = 3'b111;

  // BRANCH func3
  localparam logic [2:0] INST_BEQ  = 3'b000;
  localparam logic [2:0] INST_BNE  = 3'b001;
  localparam logic [2:0] INST_BLT  = 3'b100;
  localparam logic [2:0] INST_BGE  = 3'b101;
  localparam logic [2:0] INST_BLTU = 3'b110;
  localparam logic [2:0] INST_BGEU = 3'b111;

  localparam logic [6:0] FUNC7_BASE = 7'b0000000;
  localparam logic [6:0] FUNC7_ALT  = 7'b0100000;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_OP_ADD  = 4'd0,
    ALU_OP_SUB  = 4'd1,
    ALU_OP_SLL  = 4'd2,
    ALU_OP_SLT  = 4'd3,
    ALU_OP_SLTU = 4'd4,
    ALU_OP_XOR  = 4'd5,
    ALU_OP_SRL  = 4'd6,
    ALU_OP_SRA  = 4'd7,
    ALU_OP_OR   = 4'd8,
    ALU_OP_AND  = 4'd9,
    ALU_OP_BEQ  = 4'd10,
    ALU_OP_BNE  = 4'd11,
    ALU_OP_BLT  = 4'd12,
    ALU_OP_BGE  = 4'd13,
    ALU_OP_BLTU = 4'd14,
    ALU_OP_BGEU = 4'd15
  } alu_op_e;

  // Non-datapath part of the EX bundle; all-zero is the reset / illegal form
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_wen;
    alu_op_e               alu_op;
    logic                  branch;
    logic                  jump;
    logic                  illegal;
  } dec_ctrl_t;

endpackage

// File: rtl/id_imm_gen.sv
// Combinational immediate extraction: I/U/B/J formats sign-extended to XLEN.
module id_imm_gen #(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     inst_i,
  output logic [XLEN-1:0] imm_i_o,
  output logic [XLEN-1:0] imm_u_o,
  output logic [XLEN-1:0] imm_b_o,
  output logic [XLEN-1:0] imm_j_o
);

  logic signed [31:0] imm_i32;
  logic signed [31:0] imm_u32;
  logic signed [31:0] imm_b32;
  logic signed [31:0] imm_j32;

  assign imm_i32 = {{20{inst_i[31]}}, inst_i[31:20]};
  assign imm_u32 = {inst_i[31:12], 12'b0};
  assign imm_b32 = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_j32 = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

  // Signed 32-bit intermediates sign-extend when XLEN is 64
  assign imm_i_o = XLEN'(imm_i32);
  assign imm_u_o = XLEN'(imm_u32);
  assign imm_b_o = XLEN'(imm_b32);
  assign imm_j_o = XLEN'(imm_j32);

endmodule

// File: rtl/id_stage.sv
// Registered RV32I/RV64I decode stage: decode, register read with write-back
// bypass, and a valid/ready pipeline register towards EX with flush.
module id_stage
  import id_stage_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [INST_W-1:0]     inst_i,
  input  logic [ADDR_W-1:0]     inst_addr_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [REG_ADDR_W-1:0] rs1_addr_o,
  output logic [REG_ADDR_W-1:0] rs2_addr_o,
  input  logic [XLEN-1:0]       rs1_data_i,
  input  logic [XLEN-1:0]       rs2_data_i,
  input  logic                  wb_wen_i,
  input  logic [REG_ADDR_W-1:0] wb_addr_i,
  input  logic [XLEN-1:0]       wb_data_i,
  input  logic                  flush_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [INST_W-1:0]     inst_o,
  output logic [ADDR_W-1:0]     inst_addr_o,
  output logic [XLEN-1:0]       op1_o,
  output logic [XLEN-1:0]       op2_o,
  output logic [XLEN-1:0]       imm_o,
  output logic [REG_ADDR_W-1:0] rd_addr_o,
  output logic                  reg_wen_o,
  output logic [ALU_OP_W-1:0]   alu_op_o,
  output logic                  branch_o,
  output logic                  jump_o,
  output logic                  illegal_o
);

  logic [6:0]            opcode;
  logic [2:0]            func3;
  logic [6:0]            func7;
  logic [REG_ADDR_W-1:0] rd;
  logic [XLEN-1:0]       imm_i, imm_u, imm_b, imm_j;
  logic [XLEN-1:0]       pc_ext;
  logic [5:0]            shamt;
  logic                  shift_bad;
  logic [XLEN-1:0]       rs1_val, rs2_val;

  logic [XLEN-1:0]       op1_c, op2_c, imm_c;
  dec_ctrl_t             ctrl_c;

  logic                  load;
  logic                  valid_q, valid_d;
  logic [INST_W-1:0]     inst_q, inst_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [XLEN-1:0]       op1_q, op1_d, op2_q, op2_d, imm_q, imm_d;
  dec_ctrl_t             ctrl_q, ctrl_d;

  assign opcode = inst_i[6:0];
  assign func3  = inst_i[14:12];
  assign func7  = inst_i[31:25];
  assign rd     = inst_i[11:7];
  assign pc_ext = XLEN'(inst_addr_i);

  assign shamt     = (XLEN == 64) ? inst_i[25:20] : {1'b0, inst_i[24:20]};
  // Only inst[30] may be set above the shift amount; inst[25] is extra at RV32
  assign shift_bad = inst_i[31] | (|inst_i[29:26]) | ((XLEN == 32) && inst_i[25]);

  id_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .inst_i  (inst_i),
    .imm_i_o (imm_i),
    .imm_u_o (imm_u),
    .imm_b_o (imm_b),
    .imm_j_o (imm_j)
  );

  // Register file read addresses
  always_comb begin
    rs1_addr_o = '0;
    rs2_addr_o = '0;
    case (opcode)
      INST_TYPE_I: rs1_addr_o = inst_i[19:15];
      INST_TYPE_R, INST_TYPE_B: begin
        rs1_addr_o = inst_i[19:15];
        rs2_addr_o = inst_i[24:20];
      end
      default: ;
    endcase
  end

  // Write-back bypass; x0 is hardwired to zero
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1_addr_o != '0)
      rs1_val = (wb_wen_i && (wb_addr_i == rs1_addr_o)) ? wb_data_i : rs1_data_i;
    if (rs2_addr_o != '0)
      rs2_val = (wb_wen_i && (wb_addr_i == rs2_addr_o)) ? wb_data_i : rs2_data_i;
  end

  // Decode
  always_comb begin
    op1_c         = '0;
    op2_c         = '0;
    imm_c         = '0;
    ctrl_c        = '0;
    ctrl_c.alu_op = ALU_OP_ADD;
    case (opcode)
      INST_TYPE_I: begin
        op1_c          = rs1_val;
        op2_c          = imm_i;
        ctrl_c.rd      = rd;
        ctrl_c.reg_wen = 1'b1;
        case (func3)
          INST_ADD:  ctrl_c.alu_op = ALU_OP_ADD;
          INST_SLT:  ctrl_c.alu_op = ALU_OP_SLT;
          INST_SLTU: ctrl_c.alu_op = ALU_OP_SLTU;
          INST_XOR:  ctrl_c.alu_op = ALU_OP_XOR;
          INST_OR:   ctrl_c.alu_op = ALU_OP_OR;
          INST_AND:  ctrl_c.alu_op = ALU_OP_AND;
          INST_SLL: begin
            ctrl_c.alu_op  = ALU_OP_SLL;
            op2_c          = XLEN'(shamt);
            ctrl_c.illegal = shift_bad;
          end
          INST_SR: begin
            ctrl_c.alu_op  = inst_i[30] ? ALU_OP_SRA : ALU_OP_SRL;
            op2_c          = XLEN'(shamt);
            ctrl_c.illegal = shift_bad;
          end
          default: ;
        endcase
      end
      INST_TYPE_R: begin
        op1_c          = rs1_val;
        op2_c          = rs2_val;
        ctrl_c.rd      = rd;
        ctrl_c.reg_wen = 1'b1;
        if (func7 == FUNC7_BASE) begin
          case (func3)
            INST_ADD:  ctrl_c.alu_op = ALU_OP_ADD;
            INST_SLL:  ctrl_c.alu_op = ALU_OP_SLL;
            INST_SLT:  ctrl_c.alu_op = ALU_OP_SLT;
            INST_SLTU: ctrl_c.alu_op = ALU_OP_SLTU;
            INST_XOR:  ctrl_c.alu_op = ALU_OP_XOR;
            INST_SR:   ctrl_c.alu_op = ALU_OP_SRL;
            INST_OR:   ctrl_c.alu_op = ALU_OP_OR;
            INST_AND:  ctrl_c.alu_op = ALU_OP_AND;
            default: ;
          endcase
        end else if (func7 == FUNC7_ALT && func3 == INST_ADD) begin
          ctrl_c.alu_op = ALU_OP_SUB;
        end else if (func7 == FUNC7_ALT && func3 == INST_SR) begin
          ctrl_c.alu_op = ALU_OP_SRA;
        end else begin
          ctrl_c.illegal = 1'b1;
        end
      end
      INST_TYPE_U_LUI: begin
        op2_c          = imm_u;
        ctrl_c.rd      = rd;
        ctrl_c.reg_wen = 1'b1;
      end
      INST_TYPE_U_AUIPC: begin
        op1_c          = pc_ext;
        op2_c          = imm_u;
        ctrl_c.rd      = rd;
        ctrl_c.reg_wen = 1'b1;
      end
      INST_JAL: begin
        op1_c          = pc_ext;
        op2_c          = XLEN'(32'd4);
        imm_c          = imm_j;
        ctrl_c.rd      = rd;
        ctrl_c.reg_wen = 1'b1;
        ctrl_c.jump    = 1'b1;
      end
      INST_TYPE_B: begin
        op1_c         = rs1_val;
        op2_c         = rs2_val;
        imm_c         = imm_b;
        ctrl_c.branch = 1'b1;
        case (func3)
          INST_BEQ:  ctrl_c.alu_op = ALU_OP_BEQ;
          INST_BNE:  ctrl_c.alu_op = ALU_OP_BNE;
          INST_BLT:  ctrl_c.alu_op = ALU_OP_BLT;
          INST_BGE:  ctrl_c.alu_op = ALU_OP_BGE;
          INST_BLTU: ctrl_c.alu_op = ALU_OP_BLTU;
          INST_BGEU: ctrl_c.alu_op = ALU_OP_BGEU;
          default:   ctrl_c.illegal = 1'b1;
        endcase
      end
      default: ctrl_c.illegal = 1'b1;
    endcase

    if (ctrl_c.rd == '0) ctrl_c.reg_wen = 1'b0;

    // Illegal instructions travel to EX as an inert bundle so it can trap
    if (ctrl_c.illegal) begin
      op1_c          = '0;
      op2_c          = '0;
      imm_c          = '0;
      ctrl_c         = '0;
      ctrl_c.illegal = 1'b1;
    end
  end

  assign in_ready_o = !valid_q || out_ready_i;
  assign load       = in_valid_i && in_ready_o && !flush_i;

  // Pipeline register next state; flush wins over any transfer
  always_comb begin
    valid_d = valid_q;
    inst_d  = inst_q;
    addr_d  = addr_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    imm_d   = imm_q;
    ctrl_d  = ctrl_q;
    if (flush_i)         valid_d = 1'b0;
    else if (in_ready_o) valid_d = in_valid_i;
    if (load) begin
      inst_d = inst_i;
      addr_d = inst_addr_i;
      op1_d  = op1_c;
      op2_d  = op2_c;
      imm_d  = imm_c;
      ctrl_d = ctrl_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      inst_q  <= '0;
      addr_q  <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      imm_q   <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      inst_q  <= inst_d;
      addr_q  <= addr_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      imm_q   <= imm_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign out_valid_o = valid_q;
  assign inst_o      = inst_q;
  assign inst_addr_o = addr_q;
  assign op1_o       = op1_q;
  assign op2_o       = op2_q;
  assign imm_o       = imm_q;
  assign rd_addr_o   = ctrl_q.rd;
  assign reg_wen_o   = ctrl_q.reg_wen;
  assign alu_op_o    = ctrl_q.alu_op;
  assign branch_o    = ctrl_q.branch;
  assign jump_o      = ctrl_q.jump;
  assign illegal_o   = ctrl_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage (XLEN=32): directed test-plan steps, then random traffic
// against an ISA-level reference model of the decode and the handshake.
module tb_id_stage;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned ADDR_W = 32;

  logic              clk;
  logic              rst_n;
  logic [31:0]       inst_i;
  logic [ADDR_W-1:0] inst_addr_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [4:0]        rs1_addr_o, rs2_addr_o;
  logic [XLEN-1:0]   rs1_data_i, rs2_data_i;
  logic              wb_wen_i;
  logic [4:0]        wb_addr_i;
  logic [XLEN-1:0]   wb_data_i;
  logic              flush_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [31:0]       inst_o;
  logic [ADDR_W-1:0] inst_addr_o;
  logic [XLEN-1:0]   op1_o, op2_o, imm_o;
  logic [4:0]        rd_addr_o;
  logic              reg_wen_o;
  logic [3:0]        alu_op_o;
  logic              branch_o, jump_o, illegal_o;

  id_stage #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .inst_i      (inst_i),
    .inst_addr_i (inst_addr_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .rs1_addr_o  (rs1_addr_o),
    .rs2_addr_o  (rs2_addr_o),
    .rs1_data_i  (rs1_data_i),
    .rs2_data_i  (rs2_data_i),
    .wb_wen_i    (wb_wen_i),
    .wb_addr_i   (wb_addr_i),
    .wb_data_i   (wb_data_i),
    .flush_i     (flush_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .inst_o      (inst_o),
    .inst_addr_o (inst_addr_o),
    .op1_o       (op1_o),
    .op2_o       (op2_o),
    .imm_o       (imm_o),
    .rd_addr_o   (rd_addr_o),
    .reg_wen_o   (reg_wen_o),
    .alu_op_o    (alu_op_o),
    .branch_o    (branch_o),
    .jump_o      (jump_o),
    .illegal_o   (illegal_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file contents; x0 deliberately holds garbage
  logic [31:0] regs [32];
  assign rs1_data_i = regs[rs1_addr_o];
  assign rs2_data_i = regs[rs2_addr_o];

  typedef struct packed {
    logic        v;
    logic [31:0] inst, pc, op1, op2, imm;
    logic [4:0]  rd;
    logic        wen;
    logic [3:0]  alu;
    logic        br, jmp, ill;
  } exp_t;

  exp_t exp_q;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  function automatic logic [31:0] rdval(input logic [4:0] a, input logic wbw,
                                        input logic [4:0] wba, input logic [31:0] wbd);
    if (a == 5'd0) return 32'd0;
    if (wbw && wba == a) return wbd;
    return regs[a];
  endfunction

  // ISA-level decode of one instruction into the expected EX bundle
  function automatic exp_t model(input logic [31:0] in, input logic [31:0] pc, input logic wbw,
                                 input logic [4:0] wba, input logic [31:0] wbd);
    exp_t        e;
    logic [3:0]  base_alu [8];
    logic [3:0]  br_alu [8];
    int          f3;
    logic [6:0]  f7;
    logic [31:0] a, b, iimm, uimm, bimm, jimm;
    logic [12:0] braw;
    logic [20:0] jraw;
    base_alu = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    br_alu   = '{4'd10, 4'd11, 4'd0, 4'd0, 4'd12, 4'd13, 4'd14, 4'd15};
    f3   = int'(in[14:12]);
    f7   = in[31:25];
    a    = rdval(in[19:15], wbw, wba, wbd);
    b    = rdval(in[24:20], wbw, wba, wbd);
    iimm = 32'($signed(in) >>> 20);
    uimm = in & 32'hFFFF_F000;
    braw = {in[31], in[7], in[30:25], in[11:8], 1'b0};
    jraw = {in[31], in[19:12], in[20], in[30:21], 1'b0};
    bimm = {{19{braw[12]}}, braw};
    jimm = {{11{jraw[20]}}, jraw};
    e = '0;
    e.v = 1'b1; e.inst = in; e.pc = pc;
    case (in[6:0])
      7'h13: begin
        e.op1 = a; e.rd = in[11:7]; e.wen = 1'b1;
        e.alu = base_alu[f3]; e.op2 = iimm;
        if (f3 == 1 || f3 == 5) begin
          e.op2 = {27'd0, in[24:20]};
          if (f3 == 5 && in[30]) e.alu = 4'd7;
          e.ill = (f7 & 7'b1011111) != 7'd0;
        end
      end
      7'h33: begin
        e.op1 = a; e.op2 = b; e.rd = in[11:7]; e.wen = 1'b1;
        if (f7 == 7'h00)                 e.alu = base_alu[f3];
        else if (f7 == 7'h20 && f3 == 0) e.alu = 4'd1;
        else if (f7 == 7'h20 && f3 == 5) e.alu = 4'd7;
        else                             e.ill = 1'b1;
      end
      7'h37: begin e.op2 = uimm; e.rd = in[11:7]; e.wen = 1'b1; end
      7'h17: begin e.op1 = pc; e.op2 = uimm; e.rd = in[11:7]; e.wen = 1'b1; end
      7'h6F: begin
        e.op1 = pc; e.op2 = 32'd4; e.imm = jimm; e.jmp = 1'b1;
        e.rd = in[11:7]; e.wen = 1'b1;
      end
      7'h63: begin
        e.op1 = a; e.op2 = b; e.imm = bimm; e.br = 1'b1;
        if (f3 == 2 || f3 == 3) e.ill = 1'b1;
        else                    e.alu = br_alu[f3];
      end
      default: e.ill = 1'b1;
    endcase
    if (e.rd == 5'd0) e.wen = 1'b0;
    if (e.ill) begin
      e.op1 = '0; e.op2 = '0; e.imm = '0; e.rd = '0; e.wen = 1'b0;
      e.alu = 4'd0; e.br = 1'b0; e.jmp = 1'b0;
    end
    return e;
  endfunction

  task automatic check_out();
    chk("out_valid", 64'(out_valid_o), 64'(exp_q.v));
    chk("inst", 64'(inst_o), 64'(exp_q.inst));
    chk("inst_addr", 64'(inst_addr_o), 64'(exp_q.pc));
    chk("op1", 64'(op1_o), 64'(exp_q.op1));
    chk("op2", 64'(op2_o), 64'(exp_q.op2));
    chk("imm", 64'(imm_o), 64'(exp_q.imm));
    chk("rd", 64'(rd_addr_o), 64'(exp_q.rd));
    chk("reg_wen", 64'(reg_wen_o), 64'(exp_q.wen));
    chk("alu_op", 64'(alu_op_o), 64'(exp_q.alu));
    chk("branch", 64'(branch_o), 64'(exp_q.br));
    chk("jump", 64'(jump_o), 64'(exp_q.jmp));
    chk("illegal", 64'(illegal_o), 64'(exp_q.ill));
  endtask

  // One clock of traffic: drive at negedge, check comb outputs, then check the
  // registered bundle just after the following rising edge.
  task automatic step(input logic v, input logic [31:0] in, input logic [31:0] pc,
                      input logic rdy, input logic fl, input logic wbw,
                      input logic [4:0] wba, input logic [31:0] wbd);
    exp_t       nxt;
    logic [6:0] opc;
    @(negedge clk);
    in_valid_i = v; inst_i = in; inst_addr_i = pc; out_ready_i = rdy;
    flush_i = fl; wb_wen_i = wbw; wb_addr_i = wba; wb_data_i = wbd;
    #1;
    opc = in[6:0];
    chk("in_ready", 64'(in_ready_o), 64'(!exp_q.v || rdy));
    chk("rs1_addr", 64'(rs1_addr_o),
        64'((opc == 7'h13 || opc == 7'h33 || opc == 7'h63) ? in[19:15] : 5'd0));
    chk("rs2_addr", 64'(rs2_addr_o),
        64'((opc == 7'h33 || opc == 7'h63) ? in[24:20] : 5'd0));
    nxt = exp_q;
    if (fl)                      nxt.v = 1'b0;
    else if (!exp_q.v || rdy)    nxt = v ? model(in, pc, wbw, wba, wbd) : '{v: 1'b0, default: 'x};
    if (!fl && (!exp_q.v || rdy) && !v) begin
      nxt   = exp_q;
      nxt.v = 1'b0;
    end
    exp_q = nxt;
    @(posedge clk);
    #1;
    check_out();
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    int          k;
    r = $urandom;
    k = $urandom_range(0, 9);
    if ($urandom_range(0, 1) == 1) begin
      r[19:15] = 5'($urandom_range(0, 3));
      r[24:20] = 5'($urandom_range(0, 3));
    end
    case (k)
      0: r[6:0] = 7'h13;
      1: begin
        r[6:0]   = 7'h13;
        r[14:12] = ($urandom_range(0, 1) == 1) ? 3'd1 : 3'd5;
        if ($urandom_range(0, 3) != 0)
          r[31:25] = {1'b0, (r[14:12] == 3'd5) ? r[30] : 1'b0, 5'd0};
      end
      2, 3: begin
        r[6:0] = 7'h33;
        case ($urandom_range(0, 2))
          0: r[31:25] = 7'h00;
          1: r[31:25] = 7'h20;
          default: ;
        endcase
      end
      4: r[6:0] = 7'h37;
      5: r[6:0] = 7'h17;
      6: r[6:0] = 7'h6F;
      7, 8: r[6:0] = 7'h63;
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    logic [31:0] ri;
    logic [4:0]  wa;
    rst_n = 1'b0;
    in_valid_i = 1'b0; inst_i = '0; inst_addr_i = '0; out_ready_i = 1'b0;
    flush_i = 1'b0; wb_wen_i = 1'b0; wb_addr_i = '0; wb_data_i = '0;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[0] = 32'hDEAD_BEEF;
    regs[1] = 32'd10;
    regs[2] = 32'd3;
    exp_q = '0;

    repeat (2) @(posedge clk);
    #1;
    check_out();
    @(negedge clk);
    rst_n = 1'b1;

    // ADDI x1,x0,-1
    step(1'b1, 32'hFFF0_0093, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("addi_op1", 64'(op1_o), 64'h0);
    chk("addi_op2", 64'(op2_o), 64'hFFFF_FFFF);
    chk("addi_rd", 64'(rd_addr_o), 64'd1);
    chk("addi_wen", 64'(reg_wen_o), 64'd1);
    chk("addi_valid", 64'(out_valid_o), 64'd1);

    // SUB x3,x1,x2 with write-back of x2 in flight
    step(1'b1, 32'h4020_81B3, 32'h4, 1'b1, 1'b0, 1'b1, 5'd2, 32'd7);
    chk("sub_op1", 64'(op1_o), 64'd10);
    chk("sub_op2_bypass", 64'(op2_o), 64'd7);
    chk("sub_alu", 64'(alu_op_o), 64'd1);

    // func7 0x40 is not a valid OP encoding
    step(1'b1, 32'h8020_81B3, 32'h8, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("f7_40_illegal", 64'(illegal_o), 64'd1);
    chk("f7_40_wen", 64'(reg_wen_o), 64'd0);

    // LUI x5 then LUI x0
    step(1'b1, 32'h1234_52B7, 32'hC, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("lui_op1", 64'(op1_o), 64'd0);
    chk("lui_op2", 64'(op2_o), 64'h1234_5000);
    step(1'b1, 32'h1234_5037, 32'h10, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("lui_x0_wen", 64'(reg_wen_o), 64'd0);

    // BEQ x1,x2,+8 at 0x100
    step(1'b1, 32'h0020_8463, 32'h100, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("beq_branch", 64'(branch_o), 64'd1);
    chk("beq_imm", 64'(imm_o), 64'd8);
    chk("beq_wen", 64'(reg_wen_o), 64'd0);
    chk("beq_alu", 64'(alu_op_o), 64'd10);
    chk("beq_pc", 64'(inst_addr_o), 64'h100);

    // Backpressure: hold ADDI x4,x0,5 while ADDI x5,x0,7 waits
    step(1'b1, 32'h0050_0213, 32'h200, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    repeat (3) begin
      step(1'b1, 32'h0070_0293, 32'h204, 1'b0, 1'b0, 1'b1, 5'd4, 32'h55);
      chk("hold_rd", 64'(rd_addr_o), 64'd4);
      chk("hold_op2", 64'(op2_o), 64'd5);
    end
    step(1'b1, 32'h0070_0293, 32'h204, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("release_rd", 64'(rd_addr_o), 64'd5);
    chk("release_op2", 64'(op2_o), 64'd7);
    step(1'b0, 32'h0070_0293, 32'h204, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("drain_valid", 64'(out_valid_o), 64'd0);
    chk("drain_rd_kept", 64'(rd_addr_o), 64'd5);

    // Flush with a held bundle, then flush with a transfer in the same cycle
    step(1'b1, 32'h0090_0313, 32'h300, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    step(1'b1, 32'h0010_0393, 32'h304, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
    chk("flush_hold_valid", 64'(out_valid_o), 64'd0);
    step(1'b1, 32'h0010_0393, 32'h304, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
    chk("flush_xfer_valid", 64'(out_valid_o), 64'd0);
    chk("flush_xfer_rd", 64'(rd_addr_o), 64'd6);

    // Asynchronous reset mid-stream
    step(1'b1, 32'hFFF0_0093, 32'h400, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q = '0;
    check_out();
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      ri = rand_inst();
      case ($urandom_range(0, 3))
        0: wa = ri[19:15];
        1: wa = ri[24:20];
        2: wa = 5'd0;
        default: wa = 5'($urandom);
      endcase
      regs[$urandom_range(1, 31)] = $urandom;
      step($urandom_range(0, 9) < 7, ri, $urandom, $urandom_range(0, 9) < 7,
           $urandom_range(0, 9) == 0, 1'($urandom), wa, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
